// File: rtl/servo_frame_scheduler.sv
// servo_frame_scheduler
//   Converts 16-bin magnitude frames into servo pulse widths and drives all
//   channels on one shared frame period. Channel start times are staggered by
//   SLOT_US so that at most two outputs are high at once. New widths are
//   double-buffered: a frame lands in a shadow buffer and is copied into the
//   active widths only when the period counter wraps.
//
// Ports
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   enable        allows new pulses to start (sampled at each channel's start tick)
//   mag_valid     frame valid from the FFT
//   mag           magnitude frame, NCH bins of MAG_W bits
//   mag_ready     shadow buffer empty, a frame can be accepted
//   pulse_out     registered servo pulses
//   period_start  one-clock strobe after the period counter wraps to 0
module servo_frame_scheduler #(
  parameter int unsigned FCLK      = 50000000,
  parameter int unsigned PERIOD_US = 20000,
  parameter int unsigned MIN_US    = 1000,
  parameter int unsigned MAX_US    = 2000,
  parameter int unsigned NCH       = 16,
  parameter int unsigned MAG_W     = 17,
  parameter int unsigned MAG_SHIFT = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             mag_valid,
  input  logic [MAG_W-1:0] mag [0:NCH-1],
  output logic             mag_ready,
  output logic [NCH-1:0]   pulse_out,
  output logic             period_start
);

  localparam int unsigned SLOT_US  = (PERIOD_US - MAX_US) / NCH;
  localparam int unsigned TICK_DIV = FCLK / 1000000;
  localparam int unsigned RANGE_US = MAX_US - MIN_US;
  localparam int unsigned PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W    = $clog2(PERIOD_US);
  localparam int unsigned W_W      = $clog2(MAX_US + 1);

  if (SLOT_US * (NCH - 1) + MAX_US >= PERIOD_US) begin : g_chk_slot
    $fatal(1, "servo_frame_scheduler: last slot plus MAX_US does not fit in the period");
  end
  if (MIN_US >= MAX_US) begin : g_chk_range
    $fatal(1, "servo_frame_scheduler: MIN_US must be below MAX_US");
  end
  if (TICK_DIV < 1) begin : g_chk_tick
    $fatal(1, "servo_frame_scheduler: FCLK must be at least 1 MHz");
  end

  logic [PS_W-1:0]  presc;
  logic [CNT_W-1:0] us_cnt;
  logic             us_tick;
  logic             wrap;
  logic             xfer;
  logic             shadow_full;
  logic [W_W-1:0]   shadow_w [0:NCH-1];
  logic [W_W-1:0]   active_w [0:NCH-1];

  // Clamp is applied on the shifted magnitude at 32 bits, so the sum cannot wrap.
  function automatic logic [W_W-1:0] to_width(input logic [MAG_W-1:0] m);
    logic [MAG_W-1:0] s;
    s = m >> MAG_SHIFT;
    if (32'(s) > RANGE_US) return W_W'(MAX_US);
    return W_W'(MIN_US + 32'(s));
  endfunction

  assign us_tick   = (presc == PS_W'(TICK_DIV - 1));
  assign wrap      = us_tick && (us_cnt == CNT_W'(PERIOD_US - 1));
  assign mag_ready = ~shadow_full;
  assign xfer      = mag_valid & ~shadow_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc        <= '0;
      us_cnt       <= '0;
      period_start <= 1'b0;
      shadow_full  <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
        shadow_w[i] <= W_W'(MIN_US);
        active_w[i] <= W_W'(MIN_US);
      end
    end else begin
      presc        <= us_tick ? '0 : presc + PS_W'(1);
      period_start <= wrap;
      if (us_tick) begin
        us_cnt <= wrap ? '0 : us_cnt + CNT_W'(1);
      end
      // A transfer needs an empty shadow, so it can never collide with the
      // wrap-time copy; a frame arriving on the wrap clock waits a full period.
      if (wrap && shadow_full) begin
        active_w <= shadow_w;
      end
      if (xfer) begin
        for (int unsigned i = 0; i < NCH; i++) begin
          shadow_w[i] <= to_width(mag[i]);
        end
      end
      if (xfer) begin
        shadow_full <= 1'b1;
      end else if (wrap) begin
        shadow_full <= 1'b0;
      end
    end
  end

  // Set and clear both compare the count present on the tick, so the output
  // is high for exactly width ticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_out <= '0;
    end else if (us_tick) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (enable && (us_cnt == CNT_W'(i * SLOT_US))) begin
          pulse_out[i] <= 1'b1;
        end else if (32'(us_cnt) == i * SLOT_US + 32'(active_w[i])) begin
          pulse_out[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_servo_frame_scheduler.sv
// tb_servo_frame_scheduler
//   Directed bench for servo_frame_scheduler with a time-scaled configuration
//   (2 clocks per µs, 2000 µs period, 100..200 µs widths, 112 µs slots) so
//   several full periods fit in a short run. Expected pulses (channel, start
//   offset from the period strobe, length) are queued at each period start and
//   compared when the corresponding falling edge is observed.
module tb_servo_frame_scheduler;

  localparam int FCLK      = 2000000;
  localparam int TD        = FCLK / 1000000;
  localparam int PERIOD_US = 2000;
  localparam int MIN_US    = 100;
  localparam int MAX_US    = 200;
  localparam int NCH       = 16;
  localparam int MAG_W     = 17;
  localparam int MAG_SHIFT = 7;
  localparam int SLOT_US   = (PERIOD_US - MAX_US) / NCH;

  typedef logic [MAG_W-1:0] frame_t [0:NCH-1];
  typedef struct { int ch; int start; int len; } exp_t;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           enable;
  logic           mag_valid;
  frame_t         mag;
  logic           mag_ready;
  logic [NCH-1:0] pulse_out;
  logic           period_start;

  servo_frame_scheduler #(
    .FCLK(FCLK), .PERIOD_US(PERIOD_US), .MIN_US(MIN_US), .MAX_US(MAX_US),
    .NCH(NCH), .MAG_W(MAG_W), .MAG_SHIFT(MAG_SHIFT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mag_valid(mag_valid),
    .mag(mag), .mag_ready(mag_ready), .pulse_out(pulse_out),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t sb[$];
  int   m_active [0:NCH-1];
  int   m_shadow [0:NCH-1];
  bit   m_full = 0;
  int   rise [0:NCH-1];
  int   ps_cyc = 0;
  int   max_pop = 0;
  int   base = 0;
  logic [NCH-1:0] prev;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int conv(input int m);
    int s;
    s = m >> MAG_SHIFT;
    return MIN_US + ((s > MAX_US - MIN_US) ? (MAX_US - MIN_US) : s);
  endfunction

  task automatic check_fall(input int k);
    exp_t e;
    chk($sformatf("pulse%0d_expected", k), int'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk($sformatf("pulse%0d_channel", k), k, e.ch);
      chk($sformatf("pulse%0d_start", k), rise[k] - ps_cyc, e.start);
      chk($sformatf("pulse%0d_len", k), cyc - rise[k], e.len);
    end
  endtask

  initial begin
    prev = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev   = '0;
        ps_cyc = 0;
      end else begin
        if (period_start) ps_cyc = cyc;
        for (int k = 0; k < NCH; k++) begin
          if (pulse_out[k] && !prev[k]) rise[k] = cyc;
          else if (!pulse_out[k] && prev[k]) check_fall(k);
        end
        if ($countones(pulse_out) > max_pop) max_pop = $countones(pulse_out);
        prev = pulse_out;
      end
    end
  end

  task automatic model_push(input frame_t f);
    for (int k = 0; k < NCH; k++) m_shadow[k] = conv(int'(f[k]));
    m_full = 1;
  endtask

  task automatic begin_period(input logic [NCH-1:0] mask);
    if (m_full) begin
      m_active = m_shadow;
      m_full   = 0;
    end
    max_pop = 0;
    for (int k = 0; k < NCH; k++)
      if (mask[k]) sb.push_back('{k, TD * (k * SLOT_US + 1), TD * m_active[k]});
  endtask

  task automatic close_period();
    chk("sb_drained", sb.size(), 0);
    chk("max_pop_le2", int'(max_pop <= 2), 1);
  endtask

  task automatic wait_until(input int off);
    while (cyc - base < off) @(negedge clk);
  endtask

  task automatic wait_period_start();
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < TD * PERIOD_US + 20) begin
      @(negedge clk);
      n++;
      if (period_start) seen = 1;
    end
    chk("period_start_seen", int'(seen), 1);
    base = cyc;
  endtask

  task automatic send_frame(input frame_t f, output int acc);
    int  waited;
    bit  ok;
    waited    = 0;
    ok        = 0;
    acc       = -1;
    mag       = f;
    mag_valid = 1'b1;
    while (!ok && waited < TD * PERIOD_US + 20) begin
      if (mag_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        ok  = 1;
      end else begin
        @(negedge clk);
        waited++;
      end
    end
    mag_valid = 1'b0;
    chk("xfer_accepted", int'(ok), 1);
    @(negedge clk);
  endtask

  frame_t fA, fB, fC, fD;
  int     acc;

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b1;
    mag_valid = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      mag[k]      = '0;
      fA[k]       = '0;
      fB[k]       = 17'd131071;
      fC[k]       = '0;
      fD[k]       = 17'd6400;
      m_active[k] = MIN_US;
      m_shadow[k] = MIN_US;
    end
    fA[3]  = 17'd6400;
    fA[15] = 17'd131071;
    fC[0]  = 17'd3200;
    fD[0]  = '0;

    repeat (5) @(negedge clk);
    chk("reset_pulse_out", int'(pulse_out), 0);
    chk("reset_mag_ready", int'(mag_ready), 1);
    chk("reset_period_start", int'(period_start), 0);
    reset_n = 1'b1;
    base    = 0;

    // Period 0: power-on widths, frame A lands in shadow.
    begin_period('1);
    wait_until(TD * 1000);
    send_frame(fA, acc);
    model_push(fA);
    chk("ready_low_after_xfer", int'(mag_ready), 0);
    wait_period_start();
    chk("first_period_start_cyc", base, TD * PERIOD_US);
    close_period();

    // Period 1: A active; B accepted, C held off until after the wrap.
    begin_period('1);
    wait_until(TD * 300);
    send_frame(fB, acc);
    model_push(fB);
    chk("ready_low_before_c", int'(mag_ready), 0);
    send_frame(fC, acc);
    base = ps_cyc;
    chk("c_accept_cyc", acc, base + 1);
    close_period();

    // Period 2: every channel at maximum width.
    begin_period('1);
    model_push(fC);
    wait_period_start();
    chk("max_pop_all_max", max_pop, 2);
    close_period();

    // Period 3: C active; new frame D arrives while channel 0 is high.
    begin_period('1);
    wait_until(TD * 60);
    chk("ch0_high_at_update", int'(pulse_out[0]), 1);
    send_frame(fD, acc);
    model_push(fD);
    wait_period_start();
    close_period();

    // Period 4: D active; enable low from 400 to 950 µs.
    begin_period(16'hFE0F);
    wait_until(TD * 400);
    enable = 1'b0;
    chk("ch3_high_at_disable", int'(pulse_out[3]), 1);
    wait_until(TD * 950);
    enable = 1'b1;
    wait_period_start();
    close_period();

    // Period 5: reset asserted while channels 4 and 5 are high.
    begin_period('1);
    wait_until(TD * 580);
    chk("pre_reset_pop", $countones(pulse_out), 2);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_pulse_out", int'(pulse_out), 0);
    chk("async_reset_mag_ready", int'(mag_ready), 1);
    sb.delete();
    for (int k = 0; k < NCH; k++) m_active[k] = MIN_US;
    m_full = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    base    = 0;

    // Period 6: fresh start at us_cnt 0 with power-on widths.
    begin_period('1);
    wait_period_start();
    chk("period_start_after_reset", base, TD * PERIOD_US);
    close_period();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/servo_frame_scheduler.md
Name: servo_frame_scheduler

Overview:
- Sits between fft_interface and the 16 servo outputs.
- Accepts 16-bin magnitude frames through a valid/ready handshake and converts each bin to a pulse width in µs.
- Generates all 16 servo pulses on one shared 20 ms period.
- Staggers pulse start times so no more than 2 servos are high at once (limits peak supply current).
- Width updates are applied only at period boundaries, so a pulse in progress is never altered.

Parameters:
- FCLK, 50000000: clock frequency in Hz.
- PERIOD_US, 20000: servo frame period in µs.
- MIN_US, 1000: minimum pulse width in µs.
- MAX_US, 2000: maximum pulse width in µs.
- NCH, 16: number of channels.
- MAG_W, 17: magnitude bit width.
- MAG_SHIFT, 7: right shift applied to a magnitude before the width is added.
- Localparam SLOT_US = (PERIOD_US - MAX_US) / NCH, which is 1125 with the defaults.
- Localparam TICK_DIV = FCLK / 1000000, which is 50.

Ports:
- clk  input  1  system clock
- reset_n  input  1  reset, asynchronous, active-low
- enable  input  1  allows new pulses to start
- mag_valid  input  1  frame valid from the FFT
- mag  input  [MAG_W-1:0] x [0:NCH-1]  magnitude frame
- mag_ready  output  1  shadow buffer empty; a frame can be accepted
- pulse_out  output  [NCH-1:0]  servo pulses, registered
- period_start  output  1  one-clock strobe when the period counter wraps to 0

Behaviour:
- Reset (asynchronous, immediate):
  - pulse_out = 0, period_start = 0, mag_ready = 1.
  - Prescaler = 0, us_cnt = 0.
  - Shadow buffer empty; all active widths = MIN_US.
- µs tick:
  - Prescaler counts 0..TICK_DIV-1; us_tick = 1 on the clock where the prescaler equals TICK_DIV-1.
  - us_cnt counts 0..PERIOD_US-1 and advances on us_tick.
  - The wrap to 0 happens on the us_tick where us_cnt = PERIOD_US-1; period_start = 1 on the following clock, for 1 clock.
- Handshake:
  - mag_ready = ~shadow_full.
  - A transfer occurs when mag_valid & mag_ready.
  - On a transfer, each bin is converted: w = MIN_US + min(mag >> MAG_SHIFT, MAX_US - MIN_US), computed at 11+ bits with no overflow. The result is stored in shadow, and shadow_full is set.
  - mag_valid while mag_ready = 0 causes no transfer; the FFT holds its data.
- Period-boundary update:
  - On the wrap tick, if shadow_full, all active widths are loaded from shadow and shadow_full is cleared.
  - If a transfer and the wrap occur on the same clock (shadow was empty), the new frame goes to shadow and takes effect at the next wrap.
  - With no new frame, the previous widths repeat indefinitely.
- Per-channel pulse for channel k:
  - Start: on the us_tick where the incoming us_cnt value equals k*SLOT_US, and enable = 1 on that clock, pulse_out[k] is set on that clock edge.
  - End: on the us_tick where us_cnt equals k*SLOT_US + width[k], pulse_out[k] is cleared. The high time is exactly width[k] µs (width[k]*TICK_DIV clocks).
  - The end compare uses the active width latched at that period's wrap.
- Overlap guarantee: with the defaults, at most 2 pulse_out bits are high on any clock. The last pulse ends by 16875+2000 = 18875 µs, which is less than PERIOD_US.
- enable:
  - Sampled only at each channel's start tick.
  - Deasserting it never truncates a pulse already high.
  - Reasserting it mid-period affects only channels whose start tick has not yet passed.
- Reset mid-pulse: all pulses drop immediately; the next period begins at us_cnt = 0 after release.
- Elaboration checks: fatal error if SLOT_US*(NCH-1) + MAX_US >= PERIOD_US, or if MIN_US >= MAX_US.

Test Plan:
- Reset check: pulse_out = 0 and mag_ready = 1 during reset. With no frame ever sent, channel 0 rises at us_cnt 0 and is high for 50000 clocks (1000 µs); channel 5 rises at 5625 µs.
- Single frame, mag[3] = 64000 (64000 >> 7 = 500): after the next period_start, pulse_out[3] rises at 3375 µs and is high for exactly 75000 clocks (1500 µs).
- Clamp: mag[15] = 131071 gives 2000 µs high, ending at 18875 µs. Across all 16 channels driven at the 2000 µs maximum, popcount(pulse_out) ≤ 2 on every clock.
- Backpressure: two frames sent within one period. The second sees mag_ready = 0 and waits; it is accepted the clock after period_start. The first frame's widths apply in the first period, the second frame's widths in the following period.
- Mid-period frame: mag[0] is changed while pulse_out[0] is high. The current pulse keeps its old width; the new width appears next period.
- enable dropped at 4000 µs: channel 3 (started at 3375) completes its full width; channels 4–15 stay low. Separately, reset_n is asserted mid-pulse: every pulse_out bit goes to 0 asynchronously.
